// File: rtl/ik_pkg.sv
// Shared types and constants for the two-joint arm trajectory block.
// Holds the FSM states, home pose and the constants the angle table is built from.
package ik_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MOVE
  } ik_state_e;

  localparam int IK_ANGLE_W    = 24;
  localparam int HOME_ELBOW    = 74692;
  localparam int HOME_SHOULDER = 97346;

  localparam int E_D1   = 74692;
  localparam int E_D2   = 95625;
  localparam int E_D3   = 120000;
  localparam int E_D4   = 156874;
  localparam int S_D1   = 97346;
  localparam int S_D2   = 107812;
  localparam int S_D3   = 120000;
  localparam int S_D4   = 138437;
  localparam int E_EXT  = 36000;
  localparam int S_EXT  = 18000;
  localparam int E_SKEW = 2000;
  localparam int S_SKEW = 1500;

  // Diagonal pose by ring index, then pulled in by the off-diagonal distance.
  function automatic int ik_diag(input int m, input bit shl);
    int v;
    v = 0;
    unique case (m)
      1: v = shl ? S_D1 : E_D1;
      2: v = shl ? S_D2 : E_D2;
      3: v = shl ? S_D3 : E_D3;
      default: v = shl ? S_D4 + (m - 4) * S_EXT
                       : E_D4 + (m - 4) * E_EXT;
    endcase
    return v;
  endfunction

  function automatic int ik_angle_at(input int x, input int y,
                                     input bit shl);
    int m;
    int d;
    m = (x > y) ? x : y;
    d = m - ((x > y) ? y : x);
    return ik_diag(m, shl) - d * (shl ? S_SKEW : E_SKEW);
  endfunction

endpackage

// File: rtl/ik_angle_lut.sv
// Registered grid-coordinate to servo-pulse table.
// Loads only when enabled so the held target cannot change mid-move.
module ik_angle_lut
  import ik_pkg::*;
#(
  parameter int GRID_MAX = 4,
  parameter int ANGLE_W  = IK_ANGLE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [7:0]         i_x,
  input  logic [7:0]         i_y,
  output logic [ANGLE_W-1:0] o_elbow,
  output logic [ANGLE_W-1:0] o_shoulder
);

  logic [7:0] w_x;
  logic [7:0] w_y;

  assign w_x = (i_x > 8'(GRID_MAX)) ? 8'(GRID_MAX) : i_x;
  assign w_y = (i_y > 8'(GRID_MAX)) ? 8'(GRID_MAX) : i_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_elbow    <= ANGLE_W'(HOME_ELBOW);
      o_shoulder <= ANGLE_W'(HOME_SHOULDER);
    end else if (i_en) begin
      o_elbow    <= ANGLE_W'(ik_angle_at(int'(w_x), int'(w_y), 1'b0));
      o_shoulder <= ANGLE_W'(ik_angle_at(int'(w_x), int'(w_y), 1'b1));
    end
  end

endmodule

// File: rtl/ik_trajectory.sv
// Two-joint arm mover: accepts a grid target, looks up servo pulses,
// then slews both joints toward them at a bounded rate per motion tick.
module ik_trajectory
  import ik_pkg::*;
#(
  parameter int GRID_MAX = 4,
  parameter int ANGLE_W  = IK_ANGLE_W,
  parameter int STEP     = 1000,
  parameter int TICK_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_x,
  input  logic [7:0]         cmd_y,
  output logic [ANGLE_W-1:0] elbow_angle,
  output logic [ANGLE_W-1:0] shoulder_angle,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [ANGLE_W:0] SW = (ANGLE_W+1)'(STEP);

  ik_state_e          r_st;
  ik_state_e          w_nxt;
  logic [7:0]         r_x;
  logic [7:0]         r_y;
  logic [CW-1:0]      r_cnt;
  logic [ANGLE_W-1:0] r_elb;
  logic [ANGLE_W-1:0] r_sho;
  logic               r_done;
  logic               r_err;
  logic [ANGLE_W-1:0] w_te;
  logic [ANGLE_W-1:0] w_ts;
  logic               w_hs;
  logic               w_ok;
  logic               w_at;
  logic               w_tick;

  // Sign-extended difference keeps both directions free of wrap-around.
  function automatic logic [ANGLE_W-1:0] f_step(
    input logic [ANGLE_W-1:0] i_cur,
    input logic [ANGLE_W-1:0] i_tgt
  );
    logic [ANGLE_W:0] d;
    logic [ANGLE_W:0] m;
    d = {1'b0, i_tgt} - {1'b0, i_cur};
    m = d[ANGLE_W] ? (~d + 1'b1) : d;
    if (m > SW) m = SW;
    f_step = d[ANGLE_W] ? (i_cur - m[ANGLE_W-1:0])
                        : (i_cur + m[ANGLE_W-1:0]);
  endfunction

  ik_angle_lut #(
    .GRID_MAX(GRID_MAX),
    .ANGLE_W (ANGLE_W)
  ) u_lut (
    .clk       (clk),
    .rst       (reset),
    .i_en      (r_st == S_LOOKUP),
    .i_x       (r_x),
    .i_y       (r_y),
    .o_elbow   (w_te),
    .o_shoulder(w_ts)
  );

  assign w_hs   = cmd_valid && (r_st == S_IDLE);
  assign w_ok   = (cmd_x != 8'd0) && (cmd_x <= 8'(GRID_MAX)) &&
                  (cmd_y != 8'd0) && (cmd_y <= 8'(GRID_MAX));
  assign w_at   = (r_elb == w_te) && (r_sho == w_ts);
  assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

  assign cmd_ready      = (r_st == S_IDLE);
  assign busy           = (r_st != S_IDLE);
  assign done           = r_done;
  assign err            = r_err;
  assign elbow_angle    = r_elb;
  assign shoulder_angle = r_sho;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_st <= S_IDLE;
    else       r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      S_IDLE:   if (w_hs && w_ok) w_nxt = S_LOOKUP;
      S_LOOKUP: w_nxt = S_MOVE;
      S_MOVE:   if (w_at) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x    <= 8'd1;
      r_y    <= 8'd1;
      r_cnt  <= '0;
      r_elb  <= ANGLE_W'(HOME_ELBOW);
      r_sho  <= ANGLE_W'(HOME_SHOULDER);
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (r_st == S_MOVE) && w_at;
      r_err  <= w_hs && !w_ok;
      if (w_hs && w_ok) begin
        r_x <= cmd_x;
        r_y <= cmd_y;
      end
      // Arrival is checked before the tick so a null move costs no ticks.
      if ((r_st == S_MOVE) && !w_at) begin
        if (w_tick) begin
          r_cnt <= '0;
          r_elb <= f_step(r_elb, w_te);
          r_sho <= f_step(r_sho, w_ts);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ik_trajectory.sv
// Directed bench for ik_trajectory with STEP=1000, TICK_DIV=4.
// Cycle 0 is the cycle a request is presented; samples are taken 1ns after each edge.
module tb_ik_trajectory;

  localparam int AW = 24;
  localparam int HE = 74692;
  localparam int HS = 97346;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_x = 8'd0;
  logic [7:0]    cmd_y = 8'd0;
  logic [AW-1:0] elbow_angle;
  logic [AW-1:0] shoulder_angle;
  logic          busy;
  logic          done;
  logic          err;

  int n_chk = 0;
  int n_fail = 0;
  int t_done, n_done, n_err, n_busy, n_bad, n_chg, e_at, s_at, rdy_at;

  ik_trajectory #(
    .GRID_MAX(4),
    .ANGLE_W (AW),
    .STEP    (1000),
    .TICK_DIV(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .elbow_angle   (elbow_angle),
    .shoulder_angle(shoulder_angle),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick1;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] x, input logic [7:0] y);
    cmd_x = x;
    cmd_y = y;
    cmd_valid = 1'b1;
    tick1();
    cmd_valid = 1'b0;
  endtask

  // Observe from cycle 1 until two cycles after done or the budget expires.
  task automatic watch(input int ncyc, input logic [AW-1:0] te,
                       input logic [AW-1:0] ts, input bit hold);
    logic [AW-1:0] pe;
    logic [AW-1:0] ps;
    bit eu;
    bit su;
    pe = elbow_angle;
    ps = shoulder_angle;
    eu = (te >= pe);
    su = (ts >= ps);
    t_done = -1; n_done = 0; n_err = 0; n_busy = 0;
    n_bad = 0; n_chg = 0; e_at = -1; s_at = -1; rdy_at = -1;
    for (int c = 1; c <= ncyc; c++) begin
      if (done) begin
        n_done++;
        if (t_done < 0) t_done = c;
      end
      if (err) n_err++;
      if (busy) n_busy++;
      if (done && err) n_bad++;
      if (rdy_at < 0 && c > 1 && cmd_ready) rdy_at = c;
      if (elbow_angle != pe) n_chg++;
      if (shoulder_angle != ps) n_chg++;
      if (eu ? (elbow_angle < pe || elbow_angle > te)
             : (elbow_angle > pe || elbow_angle < te)) n_bad++;
      if (su ? (shoulder_angle < ps || shoulder_angle > ts)
             : (shoulder_angle > ps || shoulder_angle < ts)) n_bad++;
      if ((eu ? elbow_angle - pe : pe - elbow_angle) > 1000) n_bad++;
      if ((su ? shoulder_angle - ps : ps - shoulder_angle) > 1000) n_bad++;
      if (e_at < 0 && elbow_angle == te) e_at = c;
      if (s_at < 0 && shoulder_angle == ts) s_at = c;
      pe = elbow_angle;
      ps = shoulder_angle;
      if (hold && done) cmd_valid = 1'b0;
      if (t_done >= 0 && c >= t_done + 2) break;
      tick1();
    end
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick1();
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_elbow", elbow_angle, HE);
    chk("rst_shoulder", shoulder_angle, HS);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick1();
    chk("rst_ready", cmd_ready, 1);

    go(8'd1, 8'd1);
    watch(20, 24'(HE), 24'(HS), 1'b0);
    chk("home_done_cyc", t_done, 3);
    chk("home_done_cnt", n_done, 1);
    chk("home_no_change", n_chg, 0);

    go(8'd0, 8'd2);
    watch(4, 24'(HE), 24'(HS), 1'b0);
    chk("x0_err_cnt", n_err, 1);
    chk("x0_busy", n_busy, 0);
    go(8'd5, 8'd1);
    watch(4, 24'(HE), 24'(HS), 1'b0);
    chk("x5_err_cnt", n_err, 1);
    chk("x5_busy", n_busy, 0);
    chk("bad_elbow", elbow_angle, HE);
    chk("bad_shoulder", shoulder_angle, HS);

    chk("m33_busy_c0", busy, 0);
    go(8'd3, 8'd3);
    chk("m33_busy_c1", busy, 1);
    chk("m33_ready_c1", cmd_ready, 0);
    watch(400, 24'd120000, 24'd120000, 1'b0);
    chk("m33_done_cyc", t_done, 187);
    chk("m33_done_cnt", n_done, 1);
    chk("m33_ready_cyc", rdy_at, 187);
    chk("m33_elbow_at", e_at, 186);
    chk("m33_shoulder_at", s_at, 94);
    chk("m33_bad", n_bad, 0);
    chk("m33_elbow", elbow_angle, 120000);
    chk("m33_shoulder", shoulder_angle, 120000);

    pulse_reset();
    chk("hold_start_elbow", elbow_angle, HE);
    go(8'd3, 8'd3);
    cmd_x = 8'd4;
    cmd_y = 8'd4;
    cmd_valid = 1'b1;
    watch(400, 24'd120000, 24'd120000, 1'b1);
    cmd_valid = 1'b0;
    chk("hold_done_cyc", t_done, 187);
    chk("hold_done_cnt", n_done, 1);
    chk("hold_err", n_err, 0);
    chk("hold_elbow", elbow_angle, 120000);
    chk("hold_shoulder", shoulder_angle, 120000);
    chk("hold_idle", busy, 0);

    pulse_reset();
    go(8'd3, 8'd3);
    watch(49, 24'd120000, 24'd120000, 1'b0);
    chk("mid_busy_c50", busy, 1);
    chk("mid_elbow_c50", elbow_angle, 86692);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_async_elbow", elbow_angle, HE);
    chk("mid_async_shoulder", shoulder_angle, HS);
    chk("mid_async_busy", busy, 0);
    tick1();
    chk("mid_no_done_a", done, 0);
    tick1();
    chk("mid_no_done_b", done, 0);
    reset = 1'b0;
    go(8'd2, 8'd2);
    watch(300, 24'd95625, 24'd107812, 1'b0);
    chk("m22_done_cyc", t_done, 87);
    chk("m22_done_cnt", n_done, 1);
    chk("m22_elbow", elbow_angle, 95625);
    chk("m22_shoulder", shoulder_angle, 107812);

    go(8'd4, 8'd4);
    watch(400, 24'd156874, 24'd138437, 1'b0);
    chk("m44_done_cyc", t_done, 251);
    chk("m44_elbow", elbow_angle, 156874);
    chk("m44_shoulder", shoulder_angle, 138437);

    go(8'd1, 8'd1);
    watch(500, 24'(HE), 24'(HS), 1'b0);
    chk("down_done_cyc", t_done, 335);
    chk("down_done_cnt", n_done, 1);
    chk("down_bad", n_bad, 0);
    chk("down_elbow", elbow_angle, HE);
    chk("down_shoulder", shoulder_angle, HS);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
